// File: rtl/parity_pkg.sv
// Shared definitions for the parity-protected adder pipeline: default sizes and the parity helper.
package parity_pkg;

   localparam int unsigned WORD_WIDTH_DEF = 4;
   localparam int unsigned LAYERS_DEF     = 4;
   localparam int unsigned CNT_WIDTH_DEF  = 8;
   localparam int unsigned PARITY_MAX_W   = 64;

   // Even parity: 1 when the word holds an odd number of ones, so word+bit is even.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/parity_adder_pipeline_if.sv
// Stream/alarm bundle between the adder pipeline and its driver.
interface parity_adder_pipeline_if
   import parity_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int unsigned LAYERS     = LAYERS_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
);
   logic                  in_valid;
   logic [WORD_WIDTH-1:0] input_vector;
   logic                  clear_alarm;
   logic                  out_valid;
   logic [WORD_WIDTH-1:0] sum;
   logic [LAYERS-1:0]     alarm_signals;
   logic                  alarm_any;
   logic [LAYERS-1:0]     alarm_sticky;
   logic [CNT_WIDTH-1:0]  err_count;

   modport master (
      output in_valid, input_vector, clear_alarm,
      input  out_valid, sum, alarm_signals, alarm_any, alarm_sticky, err_count
   );

   modport slave (
      input  in_valid, input_vector, clear_alarm,
      output out_valid, sum, alarm_signals, alarm_any, alarm_sticky, err_count
   );
endinterface

// File: rtl/parity_reg_stage.sv
// Data register with a companion even-parity bit; err_c flags a stored word/parity disagreement.
module parity_reg_stage
   import parity_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WORD_WIDTH-1:0] din,
   output logic [WORD_WIDTH-1:0] dout,
   output logic                  err_c
);
   logic [WORD_WIDTH-1:0] memory;
   logic                  parity_reg;

   // Parity is taken from the incoming word so a later flip in memory is exposed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memory     <= '0;
         parity_reg <= 1'b0;
      end else if (load) begin
         memory     <= din;
         parity_reg <= even_parity(PARITY_MAX_W'(din));
      end
   end

   assign dout  = memory;
   assign err_c = even_parity(PARITY_MAX_W'(memory)) ^ parity_reg;
endmodule

// File: rtl/parity_adder_pipeline.sv
// LAYERS-deep pipelined adder chain (sum = (LAYERS+1)*x) with parity-checked stage registers.
// Build option ALARM_STICKY_EN adds latched per-layer alarms; otherwise alarm_sticky mirrors alarm_signals.
module parity_adder_pipeline
   import parity_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int unsigned LAYERS     = LAYERS_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input logic                    clk,
   input logic                    rst_n,
   parity_adder_pipeline_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [LAYERS:0]                 v;
   logic [LAYERS:0][WORD_WIDTH-1:0] a;
   logic [LAYERS:0][WORD_WIDTH-1:0] b;
   logic [LAYERS-1:0]               err_a;
   logic [LAYERS-1:0]               err_b;
   logic [LAYERS-1:0]               alarm;
   logic                            alarm_any;
   logic [CNT_WIDTH-1:0]            err_cnt;

   assign v[0] = bus.in_valid;
   assign a[0] = bus.input_vector;
   assign b[0] = bus.input_vector;

   // Valid chain advances every cycle; bubbles travel as v=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v[LAYERS:1] <= '0;
      else        v[LAYERS:1] <= v[LAYERS-1:0];
   end

   for (genvar k = 1; k <= LAYERS; k++) begin : g_layer
      logic [WORD_WIDTH-1:0] add_c;
      assign add_c = a[k-1] + b[k-1];

      parity_reg_stage #(.WORD_WIDTH(WORD_WIDTH)) u_a (
         .clk(clk), .rst_n(rst_n), .load(v[k-1]), .din(add_c),
         .dout(a[k]), .err_c(err_a[k-1])
      );

      parity_reg_stage #(.WORD_WIDTH(WORD_WIDTH)) u_b (
         .clk(clk), .rst_n(rst_n), .load(v[k-1]), .din(b[k-1]),
         .dout(b[k]), .err_c(err_b[k-1])
      );

      assign alarm[k-1] = v[k] & (err_a[k-1] | err_b[k-1]);
   end

   assign alarm_any = |alarm;

   // Saturating alarm-cycle counter; a fresh alarm overrides a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             err_cnt <= '0;
      else if (bus.clear_alarm)               err_cnt <= alarm_any ? CNT_WIDTH'(1) : '0;
      else if (alarm_any && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_WIDTH'(1);
   end

`ifdef ALARM_STICKY_EN
   logic [LAYERS-1:0] sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               sticky <= '0;
      else if (bus.clear_alarm) sticky <= alarm;
      else                      sticky <= sticky | alarm;
   end

   assign bus.alarm_sticky = sticky;
`else
   assign bus.alarm_sticky = alarm;
`endif

   assign bus.out_valid     = v[LAYERS];
   assign bus.sum           = a[LAYERS];
   assign bus.alarm_signals = alarm;
   assign bus.alarm_any     = alarm_any;
   assign bus.err_count     = err_cnt;
endmodule
